// File: rtl/execute_muldiv_unit_if.sv
// execute_muldiv_unit_if: decode-side issue handshake and MFHI/MFLO result bus of the mul/div unit
interface execute_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [4:0]       rd_in;
  logic             out_valid;
  logic [4:0]       out_rd;
  logic [WIDTH-1:0] out_data;
  modport master(output in_valid, op, rs_data, rt_data, rd_in, input in_ready, out_valid, out_rd, out_data);
  modport slave(input in_valid, op, rs_data, rt_data, rd_in, output in_ready, out_valid, out_rd, out_data);
endinterface

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative MULT/DIV with HI/LO; MULDIV_FAST_MUL_EN selects a single-cycle multiply
module execute_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                      clock,
  input  logic                      reset_n,
  execute_muldiv_unit_if.slave      bus,
  input  logic                      flush,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          hi_out,
  output logic [WIDTH-1:0]          lo_out
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, out_data_q, out_data_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d, out_valid_q, out_valid_d;
  logic             sgn, ge;
  logic [WIDTH-1:0] mag_a, mag_b, r_sub;
  logic [WIDTH:0]   mul_sum, r_sh;
  logic [2*WIDTH-1:0] prod_f;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_p;
`endif
  assign sgn     = ~bus.op[0];
  assign mag_a   = (sgn && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
  assign mag_b   = (sgn && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;
  assign mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
  // acc holds the partial remainder, sh shifts dividend bits out and quotient bits in
  assign r_sh    = {acc_q, sh_q[WIDTH-1]};
  assign ge      = r_sh >= {1'b0, b_q};
  assign r_sub   = r_sh[WIDTH-1:0] - b_q;
  assign prod_f  = qneg_q ? -{acc_q, sh_q} : {acc_q, sh_q};
`ifdef MULDIV_FAST_MUL_EN
  assign fast_p  = (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    sh_d = sh_q;
    b_d = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    div_d = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    done_d = 1'b0;
    out_valid_d = 1'b0;
    out_rd_d = out_rd_q;
    out_data_d = out_data_q;
    if (state_q == IDLE && bus.in_valid && !flush) begin
      if (!bus.op[2]) begin
        acc_d = '0;
        sh_d = mag_a;
        b_d = mag_b;
        div_d = bus.op[1];
        // a zero divisor keeps the quotient positive so LO ends all ones and HI the dividend
        qneg_d = sgn & (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]) & (|bus.rt_data);
        rneg_d = sgn & bus.rs_data[WIDTH-1];
        cnt_d = CNT_W'(WIDTH-1);
        state_d = bus.op[1] ? DIV : MUL;
`ifdef MULDIV_FAST_MUL_EN
        if (!bus.op[1]) begin
          {acc_d, sh_d} = fast_p;
          state_d = FIX;
        end
`endif
      end else if (!bus.op[1]) begin
        out_valid_d = 1'b1;
        out_rd_d = bus.rd_in;
        out_data_d = bus.op[0] ? lo_q : hi_q;
      end else if (bus.op[0]) lo_d = bus.rs_data;
      else hi_d = bus.rs_data;
    end else if (state_q == MUL || state_q == DIV) begin
      acc_d = (state_q == MUL) ? mul_sum[WIDTH:1] : (ge ? r_sub : r_sh[WIDTH-1:0]);
      sh_d = (state_q == MUL) ? {mul_sum[0], sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], ge};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        cnt_d = '0;
        state_d = FIX;
      end
    end else if (state_q == FIX) begin
      state_d = IDLE;
      done_d = 1'b1;
      hi_d = div_q ? (rneg_q ? -acc_q : acc_q) : prod_f[2*WIDTH-1:WIDTH];
      lo_d = div_q ? (qneg_q ? -sh_q : sh_q) : prod_f[WIDTH-1:0];
    end
    if (flush && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d = '0;
      done_d = 1'b0;
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      sh_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      div_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      done_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_rd_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sh_q <= sh_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      div_q <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      done_q <= done_d;
      out_valid_q <= out_valid_d;
      out_rd_q <= out_rd_d;
      out_data_q <= out_data_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign hi_out        = hi_q;
  assign lo_out        = lo_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: directed and random ops against an arithmetic HI/LO reference model
module tb_execute_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic busy, done;
  logic [W-1:0] hi_out, lo_out;
  logic [31:0] m_hi = '0, m_lo = '0;
  int vectors = 0, miscompares = 0;
  execute_muldiv_unit_if #(.WIDTH(W)) bus();
  execute_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus), .flush(flush),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a, b, hi, lo);
    int q, m;
    case (o)
      3'd0: return longint'($signed(a)) * longint'($signed(b));
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = int'(a) / int'(b);
        m = int'(a) % int'(b);
        return {m, q};
      end
      3'd3: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd6: return {a, lo};
      3'd7: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction
  task automatic send(input logic [2:0] o, input logic [31:0] a, b, input logic [4:0] rd, output int waited);
    waited = 0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.rd_in = rd;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    check("accept_bound", 64'(waited < 100), 64'd1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic run(input logic [2:0] o, input logic [31:0] a, b, input logic [4:0] rd);
    logic [63:0] e;
    int w, n;
    e = ref_op(o, a, b, m_hi, m_lo);
    send(o, a, b, rd, w);
    if (o < 4) begin
      check("busy_after_issue", {63'd0, busy}, 64'd1);
      check("ready_low_busy", {63'd0, bus.in_ready}, 64'd0);
      n = 0;
      while (!done && n < 100) begin
        @(posedge clock);
        #1 n++;
      end
      check("latency", 64'(n), (FAST && !o[1]) ? 64'd1 : 64'(W + 1));
      check("hi", {32'd0, hi_out}, {32'd0, e[63:32]});
      check("lo", {32'd0, lo_out}, {32'd0, e[31:0]});
      check("ready_after_done", {62'd0, bus.in_ready, busy}, 64'd2);
      @(posedge clock);
      #1 check("done_pulse", {63'd0, done}, 64'd0);
    end else if (o < 6) begin
      check("out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("out_rd", {59'd0, bus.out_rd}, {59'd0, rd});
      check("out_data", {32'd0, bus.out_data}, {32'd0, (o == 4) ? e[63:32] : e[31:0]});
      @(posedge clock);
      #1 check("out_valid_pulse", {63'd0, bus.out_valid}, 64'd0);
      check("out_data_hold", {32'd0, bus.out_data}, {32'd0, (o == 4) ? e[63:32] : e[31:0]});
    end else begin
      check("mt_hilo", {hi_out, lo_out}, e);
      check("mt_no_out", {63'd0, bus.out_valid}, 64'd0);
    end
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask
  initial begin
    logic [63:0] e;
    logic [2:0] o;
    logic [31:0] a, b;
    int w, seen;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.rd_in = '0;
    repeat (2) @(negedge clock);
    check("reset_ctl", {59'd0, bus.in_ready, busy, done, bus.out_valid, 1'b0}, 64'h10);
    check("reset_hilo", {hi_out, lo_out}, 64'd0);
    check("reset_out", {27'd0, bus.out_rd, bus.out_data}, 64'd0);
    reset_n = 1'b1;
    run(3'd0, 32'hFFFFFFFD, 32'd7, 5'd0);
    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    run(3'd3, 32'd100, 32'd7, 5'd0);
    run(3'd2, 32'hFFFFFFF9, 32'd2, 5'd0);
    run(3'd2, 32'd5, 32'd0, 5'd0);
    run(3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    run(3'd2, 32'hFFFFFFFB, 32'd0, 5'd0);
    run(3'd4, 32'd0, 32'd0, 5'd3);
    run(3'd5, 32'd0, 32'd0, 5'd4);
    e = ref_op(3'd2, 32'd1000, 32'hFFFFFFF3, m_hi, m_lo);
    send(3'd2, 32'd1000, 32'hFFFFFFF3, 5'd0, w);
    m_hi = e[63:32];
    m_lo = e[31:0];
    send(3'd4, 32'd0, 32'd0, 5'd9, w);
    check("mf_held", 64'(w > 0), 64'd1);
    check("mf_busy_valid", {58'd0, bus.out_valid, bus.out_rd}, {58'd0, 1'b1, 5'd9});
    check("mf_busy_data", {32'd0, bus.out_data}, {32'd0, m_hi});
    run(3'd7, 32'd1234, 32'd0, 5'd0);
    send(3'd2, 32'd100, 32'd7, 5'd0, w);
    repeat (9) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_idle", {62'd0, bus.in_ready, busy}, 64'd2);
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1 seen = seen | int'(done);
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hilo", {hi_out, lo_out}, {m_hi, m_lo});
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.op = 3'd6;
    bus.rs_data = 32'hDEADBEEF;
    flush = 1'b1;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_drop", {hi_out, lo_out}, {m_hi, m_lo});
    send(3'd0, 32'h12345, 32'h777, 5'd0, w);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1 check("rst_mid_ctl", {59'd0, bus.in_ready, busy, done, bus.out_valid, 1'b0}, 64'h10);
    check("rst_mid_hilo", {hi_out, lo_out}, 64'd0);
    check("rst_mid_out", {27'd0, bus.out_rd, bus.out_data}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a = 32'($urandom_range(0, 300)) - 32'd150;
        b = 32'($urandom_range(0, 20)) - 32'd10;
      end
      if ($urandom_range(0, 7) == 0) b = '0;
      run(o, a, b, 5'($urandom_range(0, 31)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
